vai_reg_burst: RTL
==================

# vai_reg_burst

Parametrised register-file slave on the VAI valid/accept/start/stop framed stream. It is the successor of the fixed 8-bit, 8-entry register block and adds configurable data width and depth, burst read and write with address auto-increment, and a coded status footer. Request frames arrive on the Din side. Response frames leave on the Dout side, each framed as header, optional data words, then a status footer.

## Interface
- `DATA_W`, default 8: data word width; must be ≥ ADDR_W+4.
- `ADDR_W`, default 4: width of the header address field.
- `REG_COUNT`, default 8: number of registers; must be ≤ 2^ADDR_W.
- `Clk_i` in 1: clock.
- `Reset_i` in 1: synchronous, active-high reset.
- `Din_i` in DATA_W: request word.
- `DinValid_i`, `DinStart_i`, `DinStop_i` in 1: request valid, first word of frame, last word of frame.
- `DinAccept_o` out 1: request word consumed when it is high together with `DinValid_i`.
- `Dout_o` out DATA_W: response word.
- `DoutValid_o`, `DoutStart_o`, `DoutStop_o` out 1: response valid, response header, response footer.
- `DoutAccept_i` in 1: downstream accept.

## Operation
- Header word layout:
  - `[3:0]` is the command: READ=0, WRITE=1, BREAD=2, BWRITE=3.
  - `[ADDR_W+3:4]` is the start address.
- Status codes: OK=0, BAD_ADDR=1, BAD_CMD=2, OVERRUN=3.
- A start address ≥ REG_COUNT gives BAD_ADDR. A burst that walks past REG_COUNT-1 gives OVERRUN.
- States: IDLE, GET_HEADER, GET_LEN, GET_WDATA, DRAIN, SEND_HEADER, SEND_DATA, SEND_FOOTER.
- IDLE → GET_HEADER unconditionally after one cycle.
- GET_HEADER:
  - Words without start are accepted and discarded.
  - A start word is captured as the header, status is cleared, and the next state depends on the command.
  - READ with stop → SEND_HEADER, count=1.
  - BREAD without stop → GET_LEN.
  - WRITE or BWRITE without stop → GET_WDATA.
  - An unknown command, or a stop/command mismatch, sets BAD_CMD. With stop it goes → SEND_HEADER; without stop it goes → DRAIN.
- GET_LEN: the accepted word sets count = Din_i[7:0]+1 (range 1..256).
  - With stop → SEND_HEADER.
  - Without stop → BAD_CMD, then DRAIN.
- GET_WDATA: each accepted word writes reg[addr+i] and i increments.
  - A write to an index ≥ REG_COUNT is dropped; it sets BAD_ADDR for i=0 and OVERRUN for i>0.
  - WRITE: the first word must carry stop, then → SEND_HEADER with count=0. A WRITE data word without stop is dropped and the block returns to IDLE with no response.
  - BWRITE: words are written until a stop word (inclusive), then → SEND_HEADER with count=0.
- DRAIN: words are accepted until a stop word, then → SEND_HEADER.
- SEND_HEADER → SEND_DATA when count>0, else → SEND_FOOTER.
- SEND_DATA:
  - Word i is reg[addr+i], or 0 if the index is ≥ REG_COUNT; that case also sets BAD_ADDR (i=0) or OVERRUN (i>0).
  - Words are sent until count words have been accepted, then → SEND_FOOTER.
- SEND_FOOTER → IDLE on accept.
- When several errors occur in one frame, the first recorded status is kept.
- Registers are never written during read or drain frames.

## Timing
- Reset, as a required priority ordering:
  - Reset has priority over everything, including reset asserted mid-frame.
  - On reset: state=IDLE, all registers=0, status=OK, and all outputs=0 (`DinAccept_o`=0, `DoutValid_o`=0, `DoutStart_o`=0, `DoutStop_o`=0, `Dout_o`=0).
- Input handshake:
  - `DinAccept_o`=1 exactly in GET_HEADER, GET_LEN, GET_WDATA and DRAIN.
  - A transfer occurs on any cycle with `DinValid_i` && `DinAccept_o`.
  - The upstream holds `Din_i`, `DinStart_i` and `DinStop_i` stable while valid and not accepted.
- A register write is visible on the cycle after the accepting edge.
- Output word sequence:
  - Every output word is preceded by exactly one cycle with `DoutValid_o`=0.
  - The register read for a data word happens in that preceding bubble cycle.
  - Entering SEND_HEADER is itself a bubble cycle.
- While `DoutValid_o` && !`DoutAccept_i`, `Dout_o`, `DoutStart_o` and `DoutStop_o` are held stable.
- `DoutStart_o` and `DoutStop_o` are never high together. `DoutStart_o` is high only in SEND_HEADER and `DoutStop_o` only in SEND_FOOTER.
- Output word contents:
  - Response header: `Dout_o` = captured header.
  - Footer: `Dout_o` = zero-extended status.
- Latency:
  - READ: the response header is valid 2 cycles after the header is accepted.
  - Best-case READ frame with `DoutAccept_i` tied high: header, bubble, data, bubble, footer.

## Structure
- Package `vai_pkg` holds:
  - command codes;
  - status codes;
  - the state enum;
  - the header field offsets.
- Sub-module `vai_regfile`, parametrised by DATA_W and REG_COUNT:
  - one synchronous write port and one registered read port;
  - synchronous clear on `Reset_i`.
- The top level contains the FSM, the index counter, the count register and the status register.

## Test plan
- READ of address 3 with reg[3]=0xA5 (header 0x30, start+stop) → output header 0x30, data 0xA5, footer 0x00, with exactly one bubble cycle before each word.
- WRITE to address 2 (header 0x21, then 0x5C with stop), followed by READ of address 2 → first response is header 0x21 and footer 0x00; the READ returns 0x5C.
- BWRITE to address 6 with 3 data words (REG_COUNT=8) → reg6 and reg7 written, third word dropped, footer 0x03. A following BREAD of address 5 with length word 0x02 → data 0, reg6, reg7, footer 0x00.
- Header 0x95 (unknown command 5) without stop, then 2 words, the last with stop → all words accepted, header 0x95 echoed, footer 0x02, no registers changed.
- READ of address 9 (REG_COUNT=8) → data 0x00, footer 0x01. In the same run, hold `DoutAccept_i`=0 for 5 cycles on every word → outputs stay stable throughout.
- Assert `Reset_i` during GET_WDATA of a BWRITE, then issue a READ → all registers read 0, no stale response is emitted, and outputs are 0 during reset.

Source files
------------

// File: rtl/vai_pkg.sv
// Shared definitions for the VAI register-burst slave: command and status
// codes, FSM state encoding and header field positions.
package vai_pkg;

  // Header command field values
  localparam logic [3:0] CMD_READ   = 4'd0;
  localparam logic [3:0] CMD_WRITE  = 4'd1;
  localparam logic [3:0] CMD_BREAD  = 4'd2;
  localparam logic [3:0] CMD_BWRITE = 4'd3;

  // Footer status values
  localparam logic [1:0] STS_OK       = 2'd0;
  localparam logic [1:0] STS_BAD_ADDR = 2'd1;
  localparam logic [1:0] STS_BAD_CMD  = 2'd2;
  localparam logic [1:0] STS_OVERRUN  = 2'd3;

  // Header field offsets: command in the low nibble, address just above it
  localparam int HDR_CMD_LSB  = 0;
  localparam int HDR_CMD_W    = 4;
  localparam int HDR_ADDR_LSB = 4;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_GET_HEADER  = 3'd1,
    S_GET_LEN     = 3'd2,
    S_GET_WDATA   = 3'd3,
    S_DRAIN       = 3'd4,
    S_SEND_HEADER = 3'd5,
    S_SEND_DATA   = 3'd6,
    S_SEND_FOOTER = 3'd7
  } vai_state_e;

  // Keep the first error seen in a frame; later errors do not overwrite it.
  function automatic logic [1:0] first_err(input logic [1:0] cur,
                                           input logic [1:0] nxt);
    return (cur == STS_OK) ? nxt : cur;
  endfunction

endpackage

// File: rtl/vai_regfile.sv
// Register array with one synchronous write port and one registered read
// port. The read register only updates when i_re is high so a fetched word
// stays put while the response waits for downstream accept.
module vai_regfile #(
  parameter int DATA_W    = 8,
  parameter int REG_COUNT = 8,
  parameter int AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [REG_COUNT];
  logic [DATA_W-1:0] r_rdata;

  // Storage update and registered read; reset clears every entry
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_waddr] <= i_wdata;
      end
      if (i_re) begin
        r_rdata <= r_mem[i_raddr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vai_reg_burst.sv
// VAI framed-stream register slave with single and burst read/write,
// address auto-increment and a coded status footer.
//
// Handshake: an input word transfers on a rising edge where DinValid_i and
// DinAccept_o are both high; an output word transfers on a rising edge where
// DoutValid_o and DoutAccept_i are both high. A presented output word and
// its flags stay frozen until it transfers.
module vai_reg_burst
  import vai_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int REG_COUNT = 8
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic [DATA_W-1:0] Din_i,
  input  logic              DinValid_i,
  input  logic              DinStart_i,
  input  logic              DinStop_i,
  output logic              DinAccept_o,
  output logic [DATA_W-1:0] Dout_o,
  output logic              DoutValid_o,
  output logic              DoutStart_o,
  output logic              DoutStop_o,
  input  logic              DoutAccept_i,
  output vai_state_e        o_dbg_state
);

  localparam int RF_AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  // Index counter is wide enough that address + index never wraps back
  // into the valid register range during a long burst.
  localparam int IDX_W = ADDR_W + 9;
  localparam logic [IDX_W:0] REG_LIMIT = (IDX_W+1)'(REG_COUNT);

  vai_state_e        r_state;
  logic [DATA_W-1:0] r_hdr;
  logic [3:0]        r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [IDX_W-1:0]  r_idx;
  logic [8:0]        r_count;
  logic [1:0]        r_status;
  logic              r_out_valid;
  logic              r_oor;

  logic              w_din_fire;
  logic              w_dout_fire;
  logic [3:0]        w_cmd;
  logic [IDX_W:0]    w_index;
  logic              w_in_range;
  logic [1:0]        w_idx_err;
  logic              w_last_data;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;

  assign DinAccept_o = (r_state == S_GET_HEADER) || (r_state == S_GET_LEN) ||
                       (r_state == S_GET_WDATA)  || (r_state == S_DRAIN);
  assign w_din_fire  = DinValid_i && DinAccept_o;
  assign w_dout_fire = r_out_valid && DoutAccept_i;
  assign w_cmd       = Din_i[HDR_CMD_LSB +: HDR_CMD_W];

  // Absolute register index of the current burst position
  assign w_index    = {{(IDX_W+1-ADDR_W){1'b0}}, r_addr} + {1'b0, r_idx};
  assign w_in_range = (w_index < REG_LIMIT);
  assign w_idx_err  = (r_idx == '0) ? STS_BAD_ADDR : STS_OVERRUN;
  assign w_last_data = ((r_idx + IDX_W'(1)) == {{(IDX_W-9){1'b0}}, r_count});

  // A lone WRITE data word without stop is discarded, never stored
  assign w_we = (r_state == S_GET_WDATA) && w_din_fire && w_in_range &&
                ((r_cmd == CMD_BWRITE) || DinStop_i);
  // Fetch happens in the bubble cycle ahead of each data word
  assign w_re = (r_state == S_SEND_DATA) && !r_out_valid;

  vai_regfile #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT),
    .AW        (RF_AW)
  ) u_regfile (
    .Clk_i   (Clk_i),
    .Reset_i (Reset_i),
    .i_we    (w_we),
    .i_waddr (w_index[RF_AW-1:0]),
    .i_wdata (Din_i),
    .i_re    (w_re),
    .i_raddr (w_index[RF_AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Frame FSM, index/count bookkeeping and status recording
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      r_state     <= S_IDLE;
      r_hdr       <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_status    <= STS_OK;
      r_out_valid <= 1'b0;
      r_oor       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_GET_HEADER;
        end

        S_GET_HEADER: begin
          if (w_din_fire && DinStart_i) begin
            r_hdr    <= Din_i;
            r_cmd    <= w_cmd;
            r_addr   <= Din_i[HDR_ADDR_LSB +: ADDR_W];
            r_idx    <= '0;
            r_count  <= '0;
            r_status <= STS_OK;
            if ((w_cmd == CMD_READ) && DinStop_i) begin
              r_count <= 9'd1;
              r_state <= S_SEND_HEADER;
            end else if ((w_cmd == CMD_BREAD) && !DinStop_i) begin
              r_state <= S_GET_LEN;
            end else if (((w_cmd == CMD_WRITE) || (w_cmd == CMD_BWRITE)) &&
                         !DinStop_i) begin
              r_state <= S_GET_WDATA;
            end else begin
              r_status <= STS_BAD_CMD;
              r_state  <= DinStop_i ? S_SEND_HEADER : S_DRAIN;
            end
          end
        end

        S_GET_LEN: begin
          if (w_din_fire) begin
            r_count <= {1'b0, Din_i[7:0]} + 9'd1;
            if (DinStop_i) begin
              r_state <= S_SEND_HEADER;
            end else begin
              r_status <= first_err(r_status, STS_BAD_CMD);
              r_state  <= S_DRAIN;
            end
          end
        end

        S_GET_WDATA: begin
          if (w_din_fire) begin
            if ((r_cmd == CMD_WRITE) && !DinStop_i) begin
              r_state <= S_IDLE;
            end else begin
              if (!w_in_range) begin
                r_status <= first_err(r_status, w_idx_err);
              end
              if (r_idx != '1) begin
                r_idx <= r_idx + IDX_W'(1);
              end
              if (DinStop_i) begin
                r_count <= '0;
                r_state <= S_SEND_HEADER;
              end
            end
          end
        end

        S_DRAIN: begin
          if (w_din_fire && DinStop_i) begin
            r_state <= S_SEND_HEADER;
          end
        end

        S_SEND_HEADER: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (w_dout_fire) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_state     <= (r_count != '0) ? S_SEND_DATA : S_SEND_FOOTER;
          end
        end

        S_SEND_DATA: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_oor       <= !w_in_range;
            if (!w_in_range) begin
              r_status <= first_err(r_status, w_idx_err);
            end
          end else if (w_dout_fire) begin
            r_out_valid <= 1'b0;
            r_idx       <= r_idx + IDX_W'(1);
            if (w_last_data) begin
              r_state <= S_SEND_FOOTER;
            end
          end
        end

        S_SEND_FOOTER: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (w_dout_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output word selection; everything is zero outside a presented word
  always_comb begin
    Dout_o = '0;
    if (r_out_valid) begin
      case (r_state)
        S_SEND_HEADER: Dout_o = r_hdr;
        S_SEND_DATA:   Dout_o = r_oor ? '0 : w_rdata;
        S_SEND_FOOTER: Dout_o = {{(DATA_W-2){1'b0}}, r_status};
        default:       Dout_o = '0;
      endcase
    end
  end

  assign DoutValid_o = r_out_valid;
  assign DoutStart_o = r_out_valid && (r_state == S_SEND_HEADER);
  assign DoutStop_o  = r_out_valid && (r_state == S_SEND_FOOTER);
  assign o_dbg_state = r_state;

endmodule
